// File: rtl/instr_issue_queue_pkg.sv
// ============================================================================
// instr_issue_queue_pkg
// Shared instruction format, opcode constants and FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_issue_queue_pkg;

  localparam int INSTR_W = 11;
  localparam int OP_W    = 3;
  localparam int REG_W   = 4;
  localparam int NUM_REG = 16;

  localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
  localparam logic [OP_W-1:0] OP_MOV  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op < 3'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // full/empty are pre-edge values, so a full FIFO rejects a write even when popped
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_issue_queue.sv
// ============================================================================
// instr_issue_queue
// Queues instructions and issues them one at a time to control_circuit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = instr_issue_queue_pkg::INSTR_W,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [INSTR_W-1:0]       wr_instr,
  input  logic                     run,
  input  logic                     cc_done,
  output logic [INSTR_W-1:0]       INSTRUCTION,
  output logic                     instr_valid,
  output logic                     issue,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               retired_cnt,
  output logic [3:0]               drop_cnt,
  output logic                     timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t               state;
  state_t               next_state;
  logic [INSTR_W-1:0]   head;
  logic [TW-1:0]        tcnt;
  logic                 pop;
  logic                 load;
  logic                 drop;
  logic                 retire;
  logic                 expire;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_instr),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    retire     = 1'b0;
    expire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && !empty) begin
          pop = 1'b1;
          if (is_legal_op(head[INSTR_W-1 -: OP_W])) begin
            load       = 1'b1;
            next_state = ST_WAIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Done takes priority over a coincident timeout
        if (cc_done) begin
          retire     = 1'b1;
          next_state = ST_IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign instr_valid = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      INSTRUCTION <= '0;
      issue       <= 1'b0;
      retired_cnt <= '0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
    end else begin
      issue <= load;
      if (load)                        INSTRUCTION <= head;
      if (retire)                      retired_cnt <= retired_cnt + 1'b1;
      if (drop && drop_cnt != 4'hF)    drop_cnt    <= drop_cnt + 1'b1;
      if (expire)                      timeout_err <= 1'b1;
      if (state == ST_WAIT && next_state == ST_WAIT) tcnt <= tcnt + 1'b1;
      else                                           tcnt <= '0;
    end
  end

endmodule

`default_nettype wire
